// File: rtl/xorgate_seq_checker_if.sv
// rtl/xorgate_seq_checker_if.sv - gate-facing bus between the sequencer and the xorgate1 cell
interface xorgate_seq_checker_if;
  logic dut_a;
  logic dut_b;
  logic dut_y;

  modport master (output dut_a, output dut_b, input dut_y);
  modport slave  (input dut_a, input dut_b, output dut_y);
endinterface

// File: rtl/xorgate_seq_checker.sv
// rtl/xorgate_seq_checker.sv - sweeps 00,01,10,11 onto a 2-input xor cell and counts mismatches
module xorgate_seq_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_PASSES  = 1,
  parameter int ERR_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  xorgate_seq_checker_if.master gate,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [1:0]            vec_idx
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  generate
    if (HOLD_CYCLES < 1 || NUM_PASSES < 1) begin : g_bad_params
      $error("xorgate_seq_checker: HOLD_CYCLES and NUM_PASSES must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [PW-1:0]    pass_cnt, pass_cnt_nxt;
  logic [1:0]       vec_nxt;
  logic             a_q, b_q, a_nxt, b_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt, err_sampled;
  logic             mismatch, last_vec, last_pass;

  assign gate.dut_a = a_q;
  assign gate.dut_b = b_q;
  assign mismatch   = gate.dut_y ^ (a_q ^ b_q);
  assign last_vec   = (vec_idx == 2'd3);
  assign last_pass  = (pass_cnt == PASS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      pass_cnt  <= '0;
      vec_idx   <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      pass_cnt  <= pass_cnt_nxt;
      vec_idx   <= vec_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      if (hold_cnt == HOLD_LAST) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (last_vec && last_pass) ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Saturating error update, used both for err_count and for the final pass verdict.
  always_comb begin
    err_sampled = err_count;
    if (mismatch && err_count != ERR_MAX) err_sampled = err_count + 1'b1;
  end

  always_comb begin
    hold_nxt     = hold_cnt;
    pass_cnt_nxt = pass_cnt;
    vec_nxt      = vec_idx;
    a_nxt        = a_q;
    b_nxt        = b_q;
    busy_nxt     = busy;
    done_nxt     = done;
    pass_nxt     = pass;
    err_nxt      = err_count;
    case (state)
      IDLE, DONE: begin
        a_nxt = 1'b0;
        b_nxt = 1'b0;
        if (start) begin
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          pass_nxt     = 1'b0;
          err_nxt      = '0;
          vec_nxt      = 2'd0;
          pass_cnt_nxt = '0;
          hold_nxt     = '0;
        end
      end
      DRIVE: begin
        a_nxt = vec_idx[1];
        b_nxt = vec_idx[0];
        if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + 1'b1;
      end
      SAMPLE: begin
        err_nxt  = err_sampled;
        hold_nxt = '0;
        if (!last_vec) begin
          vec_nxt = vec_idx + 2'd1;
          a_nxt   = vec_nxt[1];
          b_nxt   = vec_nxt[0];
        end else if (!last_pass) begin
          vec_nxt      = 2'd0;
          pass_cnt_nxt = pass_cnt + 1'b1;
          a_nxt        = 1'b0;
          b_nxt        = 1'b0;
        end else begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
          pass_nxt = (err_sampled == '0);
          a_nxt    = 1'b0;
          b_nxt    = 1'b0;
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end
endmodule
